// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has absolute priority with a fixed
// 2-cycle read latency; the CPU gets the leftover cycles through a req/ack handshake.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 31
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_disp_req,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  output logic                  o_disp_valid,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_ack,
  output logic                  o_starved,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_we,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
  localparam int STAGES = 2;
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_DATA, ACK} state_t;

  state_t          state;
  logic [STAGES:1] vld_pipe;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   cnt_inc;
  logic            issue;
  logic            blocked;

  // Issue is gated by reset so a held write request cannot touch RAM while in reset.
  always_comb begin
    issue   = !i_rst && (state == IDLE) && i_cpu_req && !i_disp_req;
    blocked = (state == IDLE) && i_cpu_req && i_disp_req;
    cnt_inc = (starve_cnt == LIM) ? starve_cnt : starve_cnt + CW'(1);
  end

  assign o_ram_addr   = i_disp_req ? i_disp_addr : i_cpu_addr;
  assign o_ram_we     = issue && i_cpu_we;
  assign o_ram_wdata  = i_cpu_wdata;
  assign o_disp_valid = vld_pipe[STAGES];

  // Display path: fixed-latency valid shift, data captured one cycle after the address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe    <= '0;
      o_disp_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], i_disp_req};
      if (vld_pipe[STAGES-1]) o_disp_data <= i_ram_rdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_cpu_ack   <= 1'b0;
      o_cpu_rdata <= '0;
      starve_cnt  <= '0;
      o_starved   <= 1'b0;
    end else begin
      o_cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= i_cpu_we ? ACK : RD_DATA;
            o_cpu_ack <= i_cpu_we;
          end
        end
        RD_DATA: begin
          o_cpu_rdata <= i_ram_rdata;
          o_cpu_ack   <= 1'b1;
          state       <= ACK;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        starve_cnt <= '0;
      end else if (blocked) begin
        starve_cnt <= cnt_inc;
        if (cnt_inc == LIM) o_starved <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a timetable model predicts every output each cycle,
// and per-cycle literal expectations pin the model against hand-computed values.
module tb_vram_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int LIMIT = 31;
  localparam int NCYC = 2048;

  localparam int L_DISP   = 1;
  localparam int L_NODISP = 2;
  localparam int L_ACKW   = 3;
  localparam int L_ACKR   = 4;
  localparam int L_NOACK  = 5;
  localparam int L_STV    = 6;
  localparam int L_RST    = 7;
  localparam int L_WCNT   = 8;

  logic          i_clk;
  logic          i_rst;
  logic          i_disp_req;
  logic [AW-1:0] i_disp_addr;
  logic [DW-1:0] o_disp_data;
  logic          o_disp_valid;
  logic          i_cpu_req;
  logic          i_cpu_we;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic [DW-1:0] o_cpu_rdata;
  logic          o_cpu_ack;
  logic          o_starved;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_we;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_data(o_disp_data), .o_disp_valid(o_disp_valid),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack),
    .o_starved(o_starved), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return DW'(32'(a) * 3);
  endfunction

  // RAM primitive: unwritten words read as addr*3.
  logic [DW-1:0] mem [NCYC];
  bit            written [NCYC];
  int            wr_count [NCYC];
  always @(posedge i_clk) begin
    if (o_ram_we) begin
      mem[o_ram_addr]      <= o_ram_wdata;
      written[o_ram_addr]  <= 1'b1;
      wr_count[o_ram_addr] <= wr_count[o_ram_addr] + 1;
    end
    i_ram_rdata <= written[o_ram_addr] ? mem[o_ram_addr] : init_word(o_ram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Literal expectations, up to two per cycle, written only by the stimulus.
  int            lit_kind [NCYC][2];
  logic [DW-1:0] lit_want [NCYC][2];

  task automatic lit(input int c, input int k, input logic [DW-1:0] w);
    int s = (lit_kind[c][0] == 0) ? 0 : 1;
    lit_kind[c][s] = k;
    lit_want[c][s] = w;
  endtask

  // Timetable model: the CPU may issue once the cycle reaches next_free.
  logic [DW-1:0] ref_mem [NCYC];
  bit            ref_written [NCYC];
  int            next_free = 0;
  int            ack_due = -1;
  bit            ack_rd;
  logic [DW-1:0] ack_data;
  int            waitc = 0;
  bit            starved_m = 0;
  logic [DW-1:0] last_disp = '0;
  logic [DW-1:0] last_rdata = '0;
  int            dq_cyc[$];
  logic [DW-1:0] dq_dat[$];
  bit            issue_m, blocked_m, exp_valid, exp_ack;
  logic [DW-1:0] w;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_written[a] ? ref_mem[a] : init_word(a);
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        next_free = 0; ack_due = -1; waitc = 0; starved_m = 0;
        last_disp = '0; last_rdata = '0;
        dq_cyc.delete(); dq_dat.delete();
        chk("rst_disp_valid", o_disp_valid === 1'b0, 32'(o_disp_valid), 32'(0));
        chk("rst_disp_data", o_disp_data === '0, 32'(o_disp_data), 32'(0));
        chk("rst_ack", o_cpu_ack === 1'b0, 32'(o_cpu_ack), 32'(0));
        chk("rst_rdata", o_cpu_rdata === '0, 32'(o_cpu_rdata), 32'(0));
        chk("rst_starved", o_starved === 1'b0, 32'(o_starved), 32'(0));
        chk("rst_ram_we", o_ram_we === 1'b0, 32'(o_ram_we), 32'(0));
      end else begin
        issue_m   = i_cpu_req && !i_disp_req && cyc >= next_free;
        blocked_m = i_cpu_req && i_disp_req && cyc >= next_free;
        exp_valid = 1'b0;
        if (dq_cyc.size() > 0 && dq_cyc[0] == cyc) begin
          exp_valid = 1'b1;
          last_disp = dq_dat[0];
          void'(dq_cyc.pop_front());
          void'(dq_dat.pop_front());
        end
        exp_ack = (ack_due == cyc);
        if (exp_ack && ack_rd) last_rdata = ack_data;

        chk("disp_valid", o_disp_valid === exp_valid, 32'(o_disp_valid), 32'(exp_valid));
        chk("disp_data", o_disp_data === last_disp, 32'(o_disp_data), 32'(last_disp));
        chk("cpu_ack", o_cpu_ack === exp_ack, 32'(o_cpu_ack), 32'(exp_ack));
        chk("cpu_rdata", o_cpu_rdata === last_rdata, 32'(o_cpu_rdata), 32'(last_rdata));
        chk("starved", o_starved === starved_m, 32'(o_starved), 32'(starved_m));
        chk("ram_addr", o_ram_addr === (i_disp_req ? i_disp_addr : i_cpu_addr),
            32'(o_ram_addr), 32'(i_disp_req ? i_disp_addr : i_cpu_addr));
        chk("ram_we", o_ram_we === (issue_m && i_cpu_we), 32'(o_ram_we), 32'(issue_m && i_cpu_we));
        chk("ram_wdata", o_ram_wdata === i_cpu_wdata, 32'(o_ram_wdata), 32'(i_cpu_wdata));

        if (blocked_m) begin
          if (waitc < LIMIT) waitc++;
          if (waitc >= LIMIT) starved_m = 1'b1;
        end
        if (issue_m) begin
          waitc = 0;
          if (i_cpu_we) begin
            ref_mem[i_cpu_addr] = i_cpu_wdata;
            ref_written[i_cpu_addr] = 1'b1;
            ack_rd = 1'b0; ack_due = cyc + 1; next_free = cyc + 2;
          end else begin
            ack_data = ref_rd(i_cpu_addr);
            ack_rd = 1'b1; ack_due = cyc + 2; next_free = cyc + 3;
          end
        end
        if (i_disp_req) begin
          dq_cyc.push_back(cyc + 2);
          dq_dat.push_back(ref_rd(i_disp_addr));
        end
      end

      if (cyc < NCYC) begin
        for (int s = 0; s < 2; s++) begin
          w = lit_want[cyc][s];
          case (lit_kind[cyc][s])
            L_DISP:   chk("lit_disp", o_disp_valid === 1'b1 && o_disp_data === w,
                          {15'b0, o_disp_valid, o_disp_data}, {16'h1, w});
            L_NODISP: chk("lit_nodisp", o_disp_valid === 1'b0, 32'(o_disp_valid), 32'(0));
            L_ACKW:   chk("lit_ackw", o_cpu_ack === 1'b1, 32'(o_cpu_ack), 32'(1));
            L_ACKR:   chk("lit_ackr", o_cpu_ack === 1'b1 && o_cpu_rdata === w,
                          {15'b0, o_cpu_ack, o_cpu_rdata}, {16'h1, w});
            L_NOACK:  chk("lit_noack", o_cpu_ack === 1'b0, 32'(o_cpu_ack), 32'(0));
            L_STV:    chk("lit_starved", o_starved === w[0], 32'(o_starved), 32'(w[0]));
            L_RST:    chk("lit_reset", {o_disp_valid, o_disp_data, o_cpu_ack, o_cpu_rdata, o_starved} === '0,
                          {o_disp_data, o_cpu_rdata}, 32'(0));
            L_WCNT:   chk("lit_wcount", wr_count[w[AW-1:0]] == 1, 32'(wr_count[w[AW-1:0]]), 32'(1));
            default: ;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = a; i_cpu_wdata = d;
    repeat (we ? 2 : 3) tick();
    i_cpu_req = 1'b0;
  endtask

  int t0;
  initial begin
    i_rst = 1'b1; i_disp_req = 1'b0; i_disp_addr = '0;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    lit(1, L_RST, 16'h0);
    lit(2, L_RST, 16'h0);
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (2) tick();

    // display stream, addresses 0..15
    t0 = cyc;
    lit(t0 + 1, L_NODISP, 16'h0);
    for (int k = 0; k < 16; k++) lit(t0 + 2 + k, L_DISP, 16'(k * 3));
    lit(t0 + 18, L_NODISP, 16'h0);
    for (int k = 0; k < 16; k++) begin
      i_disp_req = 1'b1; i_disp_addr = 11'(k);
      tick();
    end
    i_disp_req = 1'b0;
    repeat (3) tick();

    // isolated write then read of address 100
    t0 = cyc;
    lit(t0, L_NOACK, 16'h0);
    lit(t0 + 1, L_ACKW, 16'h0);
    cpu(1'b1, 11'd100, 16'hA5C3);
    repeat (2) tick();
    t0 = cyc;
    lit(t0 + 1, L_NOACK, 16'h0);
    lit(t0 + 2, L_ACKR, 16'hA5C3);
    cpu(1'b0, 11'd100, 16'h0);
    repeat (2) tick();

    // contention: CPU read of 7 against 5 display fetches of 20..24
    t0 = cyc;
    for (int k = 0; k < 5; k++) lit(t0 + 2 + k, L_DISP, 16'((20 + k) * 3));
    lit(t0 + 7, L_ACKR, 16'd21);
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 11'd7;
    for (int k = 0; k < 5; k++) begin
      i_disp_req = 1'b1; i_disp_addr = 11'(20 + k);
      tick();
    end
    i_disp_req = 1'b0;
    repeat (3) tick();
    i_cpu_req = 1'b0;
    repeat (2) tick();

    // starvation: write to 200 blocked by 40 display cycles
    t0 = cyc;
    lit(t0 + 30, L_STV, 16'h0);
    lit(t0 + 31, L_STV, 16'h1);
    lit(t0 + 41, L_ACKW, 16'h0);
    lit(t0 + 45, L_STV, 16'h1);
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 11'd200; i_cpu_wdata = 16'h1234;
    for (int k = 0; k < 40; k++) begin
      i_disp_req = 1'b1; i_disp_addr = 11'(k);
      tick();
    end
    i_disp_req = 1'b0;
    repeat (2) tick();
    i_cpu_req = 1'b0;
    repeat (4) tick();

    // reset in the RD_DATA cycle with a display fetch in flight
    i_disp_req = 1'b1; i_disp_addr = 11'd5;
    tick();
    i_disp_req = 1'b0;
    t0 = cyc;
    lit(t0 + 1, L_RST, 16'h0);
    lit(t0 + 2, L_RST, 16'h0);
    lit(t0 + 3, L_NOACK, 16'h0);
    lit(t0 + 4, L_NOACK, 16'h0);
    lit(t0 + 5, L_ACKR, 16'hA5C3);
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 11'd100;
    tick();
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    repeat (3) tick();
    i_cpu_req = 1'b0;
    repeat (2) tick();

    // back-to-back writes to 300 and 301, display reads right behind them
    t0 = cyc;
    lit(t0 + 1, L_ACKW, 16'h0);
    lit(t0 + 2, L_NOACK, 16'h0);
    lit(t0 + 3, L_ACKW, 16'h0);
    lit(t0 + 3, L_DISP, 16'h1111);
    lit(t0 + 5, L_DISP, 16'h2222);
    lit(t0 + 6, L_WCNT, 16'd300);
    lit(t0 + 7, L_WCNT, 16'd301);
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 11'd300; i_cpu_wdata = 16'h1111;
    tick();
    i_disp_req = 1'b1; i_disp_addr = 11'd300;
    tick();
    i_disp_req = 1'b0; i_cpu_addr = 11'd301; i_cpu_wdata = 16'h2222;
    tick();
    i_disp_req = 1'b1; i_disp_addr = 11'd301;
    tick();
    i_disp_req = 1'b0; i_cpu_req = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
